// File: rtl/sy_irq_gate_pkg.sv
// Shared types and width helpers for the sy_irq_gate interrupt gateway.
// Debounce is enabled by defining SY_IRQ_GATE_DEBOUNCE_EN.
package sy_irq_gate_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PULSE    = 2'd1,
      WAIT_LOW = 2'd2
   } gate_state_e;

   function automatic int deb_cnt_width(input int deb_cycles);
      return (deb_cycles < 1) ? 1 : $clog2(deb_cycles + 1);
   endfunction

   function automatic int stretch_cnt_width(input int stretch_cycles);
      return (stretch_cycles <= 1) ? 1 : $clog2(stretch_cycles);
   endfunction

endpackage

// File: rtl/sy_irq_gate_chan.sv
// One gateway channel: synchroniser, optional debounce (SY_IRQ_GATE_DEBOUNCE_EN),
// edge-to-pulse FSM or level pass-through, and sticky lost-edge flag.
module sy_irq_gate_chan
   import sy_irq_gate_pkg::*;
#(
   parameter int DEB_CYCLES     = 4,
   parameter int STRETCH_CYCLES = 8,
   parameter bit IS_EDGE        = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   input  logic lost_clr,
   output logic irq,
   output logic lost
);

   logic sync1;
   logic sync2;
   logic filt;
   logic lost_set;

   if (DEB_CYCLES < 1 || STRETCH_CYCLES < 1) begin : g_bad_param
      $error("sy_irq_gate_chan: DEB_CYCLES and STRETCH_CYCLES must be >= 1");
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

`ifdef SY_IRQ_GATE_DEBOUNCE_EN
   localparam int DEB_W = deb_cnt_width(DEB_CYCLES);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   logic [DEB_W-1:0] deb_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         deb_cnt <= '0;
         filt    <= 1'b0;
      end else if (sync2 == filt) begin
         deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
         filt    <= sync2;
         deb_cnt <= '0;
      end else begin
         deb_cnt <= deb_cnt + 1'b1;
      end
   end
`else
   assign filt = sync2;
`endif

   if (IS_EDGE) begin : g_edge
      localparam int STR_W = stretch_cnt_width(STRETCH_CYCLES);
      localparam logic [STR_W-1:0] STR_LOAD = STR_W'(STRETCH_CYCLES - 1);

      gate_state_e      state;
      gate_state_e      state_next;
      logic [STR_W-1:0] str_cnt;
      logic [STR_W-1:0] str_cnt_next;
      logic             filt_prev;
      logic             rise;

      assign rise = filt & ~filt_prev;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state     <= IDLE;
            str_cnt   <= '0;
            filt_prev <= 1'b0;
         end else begin
            state     <= state_next;
            str_cnt   <= str_cnt_next;
            filt_prev <= filt;
         end
      end

      always_comb begin
         state_next   = state;
         str_cnt_next = str_cnt;
         unique case (state)
            IDLE: begin
               if (rise) begin
                  state_next   = PULSE;
                  str_cnt_next = STR_LOAD;
               end
            end
            PULSE: begin
               // A held-high line parks in WAIT_LOW so it yields one pulse only.
               if (str_cnt == '0) begin
                  state_next = filt ? WAIT_LOW : IDLE;
               end else begin
                  str_cnt_next = str_cnt - 1'b1;
               end
            end
            WAIT_LOW: begin
               if (!filt) begin
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end

      always_comb begin
         irq      = (state == PULSE);
         lost_set = rise && (state == PULSE);
      end
   end else begin : g_level
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            irq <= 1'b0;
         end else begin
            irq <= filt;
         end
      end

      assign lost_set = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lost <= 1'b0;
      end else if (lost_set) begin
         lost <= 1'b1;
      end else if (lost_clr) begin
         lost <= 1'b0;
      end
   end

endmodule

// File: rtl/sy_irq_gate.sv
// Interrupt gateway feeding the level-triggered PLIC sources, one channel per line.
// Define SY_IRQ_GATE_DEBOUNCE_EN to enable the per-source debounce filter.
module sy_irq_gate
   import sy_irq_gate_pkg::*;
#(
   parameter int                    SOURCE_NUM     = 30,
   parameter int                    DEB_CYCLES     = 4,
   parameter int                    STRETCH_CYCLES = 8,
   parameter logic [SOURCE_NUM-1:0] EDGE_MASK      = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [SOURCE_NUM-1:0] irq_raw_i,
   output logic [SOURCE_NUM-1:0] irq_sources_o,
   output logic [SOURCE_NUM-1:0] lost_o,
   input  logic [SOURCE_NUM-1:0] lost_clr_i
);

   for (genvar i = 0; i < SOURCE_NUM; i++) begin : g_chan
      sy_irq_gate_chan #(
         .DEB_CYCLES     (DEB_CYCLES),
         .STRETCH_CYCLES (STRETCH_CYCLES),
         .IS_EDGE        (EDGE_MASK[i])
      ) u_chan (
         .clk      (clk_i),
         .rst      (rst_i),
         .raw      (irq_raw_i[i]),
         .lost_clr (lost_clr_i[i]),
         .irq      (irq_sources_o[i]),
         .lost     (lost_o[i])
      );
   end

endmodule

// File: tb/tb_sy_irq_gate.sv
// Directed scoreboard bench for sy_irq_gate: source 0 edge-type, source 1 level-type.
// Expected timing follows SY_IRQ_GATE_DEBOUNCE_EN when it is defined for the build.
module tb_sy_irq_gate;

   localparam int N   = 30;
   localparam int DEB = 4;
   localparam int STR = 8;
`ifdef SY_IRQ_GATE_DEBOUNCE_EN
   localparam int F = 2 + DEB;
`else
   localparam int F = 2;
`endif
   localparam int L = F + 1;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] raw;
   logic [N-1:0] irq;
   logic [N-1:0] lost;
   logic [N-1:0] clr;

   int cyc   = 0;
   int tests = 0;
   int fails = 0;
   int t;
   int c;

   typedef struct {
      int    at;
      string tag;
      bit    is_lost;
      int    idx;
      logic  val;
   } exp_t;

   exp_t sb[$];

   sy_irq_gate #(
      .SOURCE_NUM     (N),
      .DEB_CYCLES     (DEB),
      .STRETCH_CYCLES (STR),
      .EDGE_MASK      (30'h1)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .irq_raw_i     (raw),
      .irq_sources_o (irq),
      .lost_o        (lost),
      .lost_clr_i    (clr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect_bit(input string tag, input bit is_lost, input int idx,
                             input int from, input int to, input logic val);
      for (int k = from; k <= to; k++) begin
         sb.push_back('{k, tag, is_lost, idx, val});
      end
   endtask

   task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      tests++;
      assert (got === exp)
      else begin
         fails++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
      end
   endtask

   // Scoreboard: compare every expectation due at this cycle; overdue slots fail.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].at <= cyc) begin
            logic got;
            got = sb[i].is_lost ? lost[sb[i].idx] : irq[sb[i].idx];
            if (sb[i].at < cyc) got = 1'bx;
            tests++;
            assert (got === sb[i].val)
            else begin
               fails++;
               $error("FAIL %s cyc=%0d observed=%b expected=%b", sb[i].tag, cyc, got, sb[i].val);
            end
            sb.delete(i);
         end
      end
   end

   initial begin
      rst = 1'b0;
      raw = '0;
      clr = '0;
      #1 rst = 1'b1;
      #1;
      check("reset_irq", irq, '0);
      check("reset_lost", lost, '0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Level source: rise and fall latency
      raw[1] = 1'b1;
      t = cyc;
      expect_bit("lvl_pre", 0, 1, t + L - 1, t + L - 1, 1'b0);
      expect_bit("lvl_high", 0, 1, t + L, t + L + 19, 1'b1);
      expect_bit("lvl_edge_quiet", 0, 0, t + 1, t + L + 25, 1'b0);
      expect_bit("lvl_no_lost", 1, 1, t + 1, t + L + 25, 1'b0);
      repeat (20) @(negedge clk);
      raw[1] = 1'b0;
      t = cyc;
      expect_bit("lvl_fall", 0, 1, t + L, t + L + 3, 1'b0);
      repeat (L + 6) @(negedge clk);

`ifdef SY_IRQ_GATE_DEBOUNCE_EN
      // Glitch one cycle shorter than the debounce window is swallowed
      raw[1] = 1'b1;
      t = cyc;
      expect_bit("glitch_blocked", 0, 1, t + 1, t + L + DEB + 2, 1'b0);
      expect_bit("glitch_no_lost", 1, 1, t + 1, t + L + DEB + 2, 1'b0);
      repeat (DEB - 1) @(negedge clk);
      raw[1] = 1'b0;
      repeat (L + DEB + 4) @(negedge clk);
      // Pulse exactly as long as the window gets through
      raw[1] = 1'b1;
      t = cyc;
      expect_bit("deb_min_pre", 0, 1, t + L - 1, t + L - 1, 1'b0);
      expect_bit("deb_min_pass", 0, 1, t + L, t + L + DEB - 1, 1'b1);
      expect_bit("deb_min_end", 0, 1, t + L + DEB, t + L + DEB + 2, 1'b0);
      repeat (DEB) @(negedge clk);
      raw[1] = 1'b0;
      repeat (L + DEB + 4) @(negedge clk);
`else
      // Without debounce a single-cycle glitch propagates
      raw[1] = 1'b1;
      t = cyc;
      expect_bit("glitch_pre", 0, 1, t + L - 1, t + L - 1, 1'b0);
      expect_bit("glitch_pass", 0, 1, t + L, t + L, 1'b1);
      expect_bit("glitch_end", 0, 1, t + L + 1, t + L + 3, 1'b0);
      expect_bit("glitch_no_lost", 1, 1, t + 1, t + L + 3, 1'b0);
      @(negedge clk);
      raw[1] = 1'b0;
      repeat (L + 6) @(negedge clk);
`endif

      // Edge source held high: exactly one stretched pulse
      raw[0] = 1'b1;
      t = cyc;
      expect_bit("edge_pre", 0, 0, t + L - 1, t + L - 1, 1'b0);
      expect_bit("edge_pulse", 0, 0, t + L, t + L + STR - 1, 1'b1);
      expect_bit("edge_single", 0, 0, t + L + STR, t + 45, 1'b0);
      expect_bit("edge_no_lost", 1, 0, t + 1, t + 45, 1'b0);
      repeat (40) @(negedge clk);
      raw[0] = 1'b0;
      repeat (L + 6) @(negedge clk);

      // Lost edge: second rise lands in the last pulse cycle
      t = cyc;
      expect_bit("lost_pulse", 0, 0, t + L, t + L + STR - 1, 1'b1);
      expect_bit("lost_no_restart", 0, 0, t + L + STR, t + L + 14, 1'b0);
      expect_bit("lost_pre", 1, 0, t + L + 7, t + L + 7, 1'b0);
      expect_bit("lost_set", 1, 0, t + L + 8, t + L + 12, 1'b1);
      for (int k = 0; k < 20; k++) begin
         raw[0] = (k < 4) || (k >= 8 && k < 14);
         @(negedge clk);
      end
      repeat (L) @(negedge clk);

      c = cyc;
      clr[0] = 1'b1;
      expect_bit("clr_fall", 1, 0, c + 1, c + 3, 1'b0);
      @(negedge clk);
      clr[0] = 1'b0;
      repeat (4) @(negedge clk);

      // Clear coinciding with a new lost edge: set wins
      t = cyc;
      expect_bit("coin_pulse", 0, 0, t + L, t + L + STR - 1, 1'b1);
      expect_bit("coin_pre", 1, 0, t + L + 7, t + L + 7, 1'b0);
      expect_bit("coin_set_wins", 1, 0, t + L + 8, t + L + 10, 1'b1);
      for (int k = 0; k < 20; k++) begin
         raw[0] = (k < 4) || (k >= 8 && k < 14);
         clr[0] = (k == L + 7);
         @(negedge clk);
      end
      clr[0] = 1'b0;
      repeat (L + 2) @(negedge clk);

      // Asynchronous reset in the third pulse cycle
      raw[0] = 1'b1;
      t = cyc;
      expect_bit("rst_pulse_start", 0, 0, t + L, t + L + 1, 1'b1);
      repeat (L + 2) @(negedge clk);
      check("pre_rst_pulse", N'(irq[0]), N'(1));
      check("pre_rst_lost", N'(lost[0]), N'(1));
      #2 rst = 1'b1;
      #1;
      check("rst_mid_irq", irq, '0);
      check("rst_mid_lost", lost, '0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      t = cyc;
      expect_bit("post_rst_pre", 0, 0, t + L - 1, t + L - 1, 1'b0);
      expect_bit("post_rst_pulse", 0, 0, t + L, t + L + STR - 1, 1'b1);
      expect_bit("post_rst_end", 0, 0, t + L + STR, t + L + STR + 2, 1'b0);
      expect_bit("post_rst_no_lost", 1, 0, t + 1, t + L + STR + 2, 1'b0);
      repeat (L + STR + 4) @(negedge clk);
      raw[0] = 1'b0;

      for (int w = 0; w < 200 && sb.size() != 0; w++) @(negedge clk);
      tests++;
      assert (sb.size() == 0)
      else begin
         fails++;
         $error("FAIL sb_drain pending=%0d required=0", sb.size());
      end
      check("idle_sources", irq & ~N'(3), '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
